pe_mac_acc: RTL and testbench

PE_MAC_ACC -- requirements
Module: pe_mac_acc

---
 rtl/pe_pkg.sv | 14 +
 rtl/pe_add_tree.sv | 57 +++++
 rtl/pe_mac_acc.sv | 114 +++++++++++
 tb/tb_pe_mac_acc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the PE multiply-accumulate slice.
package pe_pkg;
  localparam int DW_DEF    = 8;
  localparam int ACCW_DEF  = 25;
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/pe_add_tree.sv
// Registered pairwise adder tree: one register level per halving, each level one bit wider.
module pe_add_tree import pe_pkg::*; #(
  parameter int N  = 3,
  parameter int IW = 16,
  localparam int L  = clog2(N),
  localparam int OW = IW + L
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [N*IW-1:0] vec_i,
  output logic [OW-1:0]   sum_o
);

  function automatic int nodes(input int lvl);
    return (N + (1 << lvl) - 1) >> lvl;
  endfunction

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NP = nodes(k - 1);
    localparam int NK = nodes(k);
    localparam int W  = IW + k;

    logic [W-2:0] src [NP];
    logic [W-1:0] node_q [NK];

    if (k == 1) begin : g_src
      for (genvar j = 0; j < NP; j++) begin : g_tap
        assign src[j] = vec_i[j*IW +: IW];
      end
    end else begin : g_src
      assign src = g_lvl[k-1].node_q;
    end

    for (genvar j = 0; j < NK; j++) begin : g_node
      if (2*j + 1 < NP) begin : g_pair
        always_ff @(posedge clk or posedge rst) begin
          if (rst)       node_q[j] <= '0;
          else if (en_i) node_q[j] <= {src[2*j][W-2], src[2*j]} + {src[2*j+1][W-2], src[2*j+1]};
        end
      end else begin : g_pass
        // odd leftover rides through so every path has the same depth
        always_ff @(posedge clk or posedge rst) begin
          if (rst)       node_q[j] <= '0;
          else if (en_i) node_q[j] <= {src[2*j][W-2], src[2*j]};
        end
      end
    end
  end

  if (L == 0) begin : g_out_direct
    assign sum_o = vec_i;
  end else begin : g_out_tree
    assign sum_o = g_lvl[L].node_q[0];
  end

endmodule

// File: rtl/pe_mac_acc.sv
// Dot-product MAC: registered multipliers, adder tree, and a group accumulator
// with wrap or saturate overflow handling and a sticky overflow flag.
module pe_mac_acc import pe_pkg::*; #(
  parameter int NTAP = 3,
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int SAT  = SAT_WRAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [NTAP*DW-1:0] ifm_vec,
  input  logic [NTAP*DW-1:0] wgt_vec,
  output logic               out_valid,
  output logic [ACCW-1:0]    p_sum,
  output logic               ovf
);

  localparam int PW = 2 * DW;
  localparam int L  = clog2(NTAP);
  localparam int TW = PW + L;

  function automatic logic [PW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
  endfunction

  logic              en;
  logic [PW-1:0]     prod_q [NTAP];
  logic [NTAP*PW-1:0] prod_vec;
  logic [L:0]        vld_q, first_q, last_q;
  logic [TW-1:0]     tree_sum;

  assign en = !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) prod_q[i] <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (en) begin
      for (int i = 0; i < NTAP; i++) prod_q[i] <= smul(ifm_vec[i*DW +: DW], wgt_vec[i*DW +: DW]);
      vld_q[0]   <= in_valid;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int s = 1; s <= L; s++) begin
        vld_q[s]   <= vld_q[s-1];
        first_q[s] <= first_q[s-1];
        last_q[s]  <= last_q[s-1];
      end
    end
  end

  for (genvar i = 0; i < NTAP; i++) begin : g_pack
    assign prod_vec[i*PW +: PW] = prod_q[i];
  end

  pe_add_tree #(.N(NTAP), .IW(PW)) u_tree (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .vec_i (prod_vec),
    .sum_o (tree_sum)
  );

  logic [ACCW-1:0] acc_q, acc_d, addend, base, p_sum_q;
  logic [ACCW:0]   full;
  logic            sticky_q, sticky_d, open_q, ovf_q, out_valid_q;
  logic            start, over;

  assign addend = ACCW'($signed(tree_sum));

  // a beat without first while no group is open still starts a fresh group
  always_comb begin
    start = first_q[L] || !open_q;
    base  = start ? '0 : acc_q;
    full  = {base[ACCW-1], base} + {addend[ACCW-1], addend};
    over  = full[ACCW] ^ full[ACCW-1];
    acc_d = full[ACCW-1:0];
    if (SAT == SAT_CLAMP && over)
      acc_d = full[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    sticky_d = (start ? 1'b0 : sticky_q) | over;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      open_q      <= 1'b0;
      p_sum_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      out_valid_q <= vld_q[L] && last_q[L];
      if (vld_q[L]) begin
        acc_q    <= acc_d;
        sticky_q <= sticky_d;
        open_q   <= !last_q[L];
        if (last_q[L]) begin
          p_sum_q <= acc_d;
          ovf_q   <= sticky_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign p_sum     = p_sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_mac_acc.sv
// Five MAC configurations share one stimulus stream and are checked against a group-level model.
module tb_pe_mac_acc;
  localparam int NI = 5;

  int ntap_a [NI] = '{3, 3, 3, 1, 5};
  int accw_a [NI] = '{25, 17, 17, 25, 25};
  int sat_a  [NI] = '{0, 1, 0, 0, 0};
  int lat_a  [NI] = '{4, 4, 4, 2, 5};

  logic        clk = 1'b0;
  logic        rst, stall, in_valid, in_first, in_last;
  logic [39:0] ifm_v, wgt_v;
  logic        ov [NI];
  logic        of [NI];
  logic [24:0] ps0, ps3, ps4;
  logic [16:0] ps1, ps2;

  always #5 clk = ~clk;

  pe_mac_acc #(.NTAP(3)) u_d0 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .ifm_vec(ifm_v[23:0]), .wgt_vec(wgt_v[23:0]), .out_valid(ov[0]), .p_sum(ps0), .ovf(of[0]));
  pe_mac_acc #(.NTAP(3), .ACCW(17), .SAT(1)) u_s17 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .ifm_vec(ifm_v[23:0]), .wgt_vec(wgt_v[23:0]), .out_valid(ov[1]), .p_sum(ps1), .ovf(of[1]));
  pe_mac_acc #(.NTAP(3), .ACCW(17), .SAT(0)) u_w17 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .ifm_vec(ifm_v[23:0]), .wgt_vec(wgt_v[23:0]), .out_valid(ov[2]), .p_sum(ps2), .ovf(of[2]));
  pe_mac_acc #(.NTAP(1)) u_n1 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .ifm_vec(ifm_v[7:0]), .wgt_vec(wgt_v[7:0]), .out_valid(ov[3]), .p_sum(ps3), .ovf(of[3]));
  pe_mac_acc #(.NTAP(5)) u_n5 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .ifm_vec(ifm_v), .wgt_vec(wgt_v), .out_valid(ov[4]), .p_sum(ps4), .ovf(of[4]));

  typedef struct {
    int     inst;
    int     due;
    longint val;
    bit     ov;
  } exp_t;

  exp_t   pend [$];
  longint acc_m [NI];
  bit     sticky_m [NI];
  bit     open_m [NI];
  bit     exp_ov [NI];
  longint exp_ps [NI];
  bit     exp_of [NI];
  int     ov_cnt [NI];
  int     ucnt;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint psum_of(input int k);
    case (k)
      0:       return longint'($signed(ps0));
      1:       return longint'($signed(ps1));
      2:       return longint'($signed(ps2));
      3:       return longint'($signed(ps3));
      default: return longint'($signed(ps4));
    endcase
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int k = 0; k < NI; k++) begin
      acc_m[k] = 0; sticky_m[k] = 0; open_m[k] = 0;
      exp_ov[k] = 0; exp_ps[k] = 0; exp_of[k] = 0;
    end
  endtask

  // group semantics: dot product per beat, load on first/idle, add otherwise
  task automatic model_beat(input int k);
    longint dot, v, lim;
    exp_t   e;
    dot = 0;
    for (int i = 0; i < ntap_a[k]; i++)
      dot += longint'($signed(ifm_v[i*8 +: 8])) * longint'($signed(wgt_v[i*8 +: 8]));
    lim = longint'(1) << (accw_a[k] - 1);
    if (in_first || !open_m[k]) begin
      acc_m[k] = 0;
      sticky_m[k] = 0;
    end
    v = acc_m[k] + dot;
    if (v >= lim || v < -lim) begin
      sticky_m[k] = 1;
      if (sat_a[k] == 1) v = (v >= lim) ? lim - 1 : -lim;
      else               v = (v >= lim) ? v - 2*lim : v + 2*lim;
    end
    acc_m[k] = v;
    open_m[k] = !in_last;
    if (in_last) begin
      e.inst = k; e.due = ucnt + lat_a[k] - 1; e.val = v; e.ov = sticky_m[k];
      pend.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!stall) begin
      ucnt++;
      if (in_valid) for (int k = 0; k < NI; k++) model_beat(k);
      for (int k = 0; k < NI; k++) begin
        exp_ov[k] = 0;
        for (int j = 0; j < pend.size(); j++) begin
          if (pend[j].inst == k && pend[j].due == ucnt) begin
            exp_ov[k] = 1; exp_ps[k] = pend[j].val; exp_of[k] = pend[j].ov;
            pend.delete(j);
            break;
          end
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      if (ov[k]) ov_cnt[k]++;
      chk($sformatf("out_valid[%0d]", k), longint'(ov[k]), longint'(exp_ov[k]));
      chk($sformatf("p_sum[%0d]", k), psum_of(k), exp_ps[k]);
      chk($sformatf("ovf[%0d]", k), longint'(of[k]), longint'(exp_of[k]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), longint'(ov[k]), 0);
      chk($sformatf("rst_p_sum[%0d]", k), psum_of(k), 0);
      chk($sformatf("rst_ovf[%0d]", k), longint'(of[k]), 0);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic beat3(input bit f, input bit l, input int a0, input int a1, input int a2,
                       input int b0, input int b1, input int b2);
    stall = 1'b0; in_valid = 1'b1; in_first = f; in_last = l;
    ifm_v = {16'h0, 8'(a2), 8'(a1), 8'(a0)};
    wgt_v = {16'h0, 8'(b2), 8'(b1), 8'(b0)};
    step();
  endtask

  task automatic idle(input int n);
    stall = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    ucnt = 0;
    ifm_v = '0; wgt_v = '0;
    for (int k = 0; k < NI; k++) ov_cnt[k] = 0;
    do_reset();

    // one-beat group, latency 4 on the NTAP=3 instance
    beat3(1, 1, 1, 2, 3, 4, 5, 6);
    idle(3);
    chk("lat4_out_valid", longint'(ov[0]), 1);
    chk("dot_psum", psum_of(0), 32);
    idle(3);

    beat3(1, 0, -128, -128, -128, -128, -128, -128);
    beat3(0, 0, 1, 1, 1, 1, 1, 1);
    beat3(0, 1, 1, 1, 1, 1, 1, 1);
    idle(6);
    chk("grp3_psum", psum_of(0), 49158);
    chk("grp3_ovf", longint'(of[0]), 0);

    beat3(1, 0, 127, 127, 127, 127, 127, 127);
    beat3(0, 0, 127, 127, 127, 127, 127, 127);
    beat3(0, 1, 127, 127, 127, 127, 127, 127);
    idle(6);
    chk("sat_psum", psum_of(1), 65535);
    chk("sat_ovf", longint'(of[1]), 1);
    chk("wrap_psum", psum_of(2), 14089);
    chk("wrap_ovf", longint'(of[2]), 1);
    chk("wide_psum", psum_of(0), 145161);

    beat3(1, 1, 1, 2, 3, 4, 5, 6);
    beat3(0, 1, 1, 1, 1, 1, 1, 1);
    idle(6);
    chk("nofirst_psum", psum_of(0), 3);

    ov_cnt[0] = 0;
    for (int g = 0; g < 8; g++) begin
      if (g == 6) begin
        repeat (3) begin
          stall = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
          ifm_v = 40'({$urandom(), $urandom()});
          wgt_v = 40'({$urandom(), $urandom()});
          step();
        end
      end
      beat3(1, 1, g + 1, 2, 3, 1, g, 1);
    end
    idle(6);
    chk("stall_ov_cycles", ov_cnt[0], 11);

    beat3(1, 0, 5, 5, 5, 5, 5, 5);
    beat3(0, 0, 5, 5, 5, 5, 5, 5);
    do_reset();
    ov_cnt[0] = 0;
    beat3(0, 1, 1, 1, 1, 1, 1, 1);
    idle(6);
    chk("rst_mid_ov_count", ov_cnt[0], 1);
    chk("rst_mid_psum", psum_of(0), 3);

    for (int c = 0; c < 600; c++) begin
      stall    = ($urandom_range(0, 99) < 15);
      in_valid = ($urandom_range(0, 99) < 70);
      in_first = ($urandom_range(0, 3) == 0);
      in_last  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: begin ifm_v = {5{8'h7f}}; wgt_v = {5{8'h7f}}; end
        1: begin ifm_v = {5{8'h80}}; wgt_v = {5{8'h7f}}; end
        default: begin
          ifm_v = 40'({$urandom(), $urandom()});
          wgt_v = 40'({$urandom(), $urandom()});
        end
      endcase
      step();
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
